// File: rtl/sub_nibble_serial_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The operand side is valid/ready into the block, and the result side is valid/ready out of it.
interface sub_nibble_serial_if #(
    parameter int WIDTH = 24
) ();
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
    logic             o_zero;

    modport master (
        output i_valid,
        output i_a,
        output i_b,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_diff,
        input  o_borrow,
        input  o_zero
    );

    modport slave (
        input  i_valid,
        input  i_a,
        input  i_b,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_diff,
        output o_borrow,
        output o_zero
    );
endinterface

// File: rtl/sub_nibble_serial.sv
// Multi-cycle unsigned subtractor that computes A - B one 4-bit carry-lookahead slice per clock.
// It adds A and ~B with a carry-in of 1, so the final carry-out is the inverse of the borrow.
module sub_nibble_serial #(
    parameter int WIDTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    sub_nibble_serial_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(N - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("sub_nibble_serial: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [4:0]       slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] next_diff;
    logic             accept;

    // One 4-bit carry-lookahead slice. The result is {cout, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign accept = (state == IDLE) && bus.i_valid && ready;

    // Slice select and write-back use a constant-index loop, so the part-selects never go out of range.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        next_diff = diff;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                slice_a = a_q[4*i +: 4];
                slice_b = ~b_q[4*i +: 4];
            end
        end
        slice_res  = cla4(slice_a, slice_b, carry);
        slice_cout = slice_res[4];
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                next_diff[4*i +: 4] = slice_res[3:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            k      <= '0;
            carry  <= 1'b1;
            ready  <= 1'b1;
            valid  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        k     <= '0;
                        carry <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                RUN: begin
                    diff  <= next_diff;
                    carry <= slice_cout;
                    k     <= k + 1'b1;
                    if (k == LAST) begin
                        state  <= DONE;
                        valid  <= 1'b1;
                        borrow <= ~slice_cout;
                        zero   <= (next_diff == '0);
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // Operands are captured only when a request is accepted, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            a_q <= bus.i_a;
            b_q <= bus.i_b;
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_valid  = valid;
    assign bus.o_diff   = diff;
    assign bus.o_borrow = borrow;
    assign bus.o_zero   = zero;
endmodule
